// File: rtl/axis_data_unpack_if.sv
// Handshake bundles for the H2C frame unpacker: the incoming 512-bit
// AXI-Stream beat channel and the reassembled payload channel.

interface axis_h2c_if #(
  parameter int W = 512
);
  logic [W-1:0]   tdata;
  logic [W/8-1:0] tkeep;
  logic           tlast;
  logic           tvalid;
  logic           tready;

  modport master (output tdata, tkeep, tlast, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

interface payload_if #(
  parameter int DW = 4064
);
  logic [DW-1:0] data;
  logic [7:0]    data_seq;
  logic          data_valid;
  logic          data_ready;

  modport master (output data, data_seq, data_valid, input data_ready);
  modport slave  (input data, data_seq, data_valid, output data_ready);
endinterface

// File: rtl/axis_data_unpack.sv
// Host-to-card frame unpacker: strips the sequence byte from beat 0, reassembles
// FRAME_BEATS beats into one DATA_WIDTH word and checks length and sequence.

module axis_data_unpack #(
  parameter int DATA_WIDTH      = 4064,
  parameter int AXIS_DATA_WIDTH = 512,
  parameter int FRAME_BEATS     = (DATA_WIDTH + 8 + AXIS_DATA_WIDTH - 1) / AXIS_DATA_WIDTH
) (
  input  logic        m_axis_h2c_aclk,
  input  logic        m_axis_h2c_areset,
  axis_h2c_if.slave   m_axis_h2c,
  payload_if.master   m_data,
  output logic        seq_err,
  output logic        frame_err,
  output logic [15:0] frame_cnt
);

  localparam int BEAT_W = AXIS_DATA_WIDTH;
  localparam int FLAT_W = (FRAME_BEATS - 1) * BEAT_W;
  localparam int CNT_W  = $clog2(FRAME_BEATS + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_BEATS - 1);

  typedef enum logic [1:0] {HEAD, BODY, DROP} state_t;

  state_t                r_state, w_state_next;
  logic [CNT_W-1:0]      r_beat_cnt, w_beat_cnt_next;
  logic                  r_run;
  logic [DATA_WIDTH-1:0] r_data;
  logic [7:0]            r_data_seq;
  logic                  r_valid;
  logic                  r_seq_err;
  logic                  r_frame_err;
  logic [15:0]           r_frame_cnt;
  logic [7:0]            r_exp_seq;
  logic                  r_exp_set;

  logic                  w_tready;
  logic                  w_hs;
  logic                  w_out_hs;
  logic                  w_complete;
  logic                  w_len_err;
  logic [FLAT_W-1:0]     w_flat;
  logic [FLAT_W+BEAT_W-1:0] w_full;
  logic                  w_unused;

  // Only the final beat can stall: earlier beats land in the assembly buffer.
  assign w_tready = r_run && !(r_state == BODY && r_beat_cnt == LAST_BEAT &&
                               r_valid && !m_data.data_ready);
  assign w_hs     = m_axis_h2c.tvalid && w_tready;
  assign w_out_hs = r_valid && m_data.data_ready;
  assign w_unused = ^m_axis_h2c.tkeep;

  // Beat slots 0..FRAME_BEATS-2; slot 0 keeps the sequence byte in its low 8 bits.
  generate
    for (genvar gi = 0; gi < FRAME_BEATS - 1; gi++) begin : g_slot
      logic [BEAT_W-1:0] r_slot;
      logic              w_wr;
      if (gi == 0) begin : g_head
        assign w_wr = w_hs && (r_state == HEAD);
      end else begin : g_body
        assign w_wr = w_hs && (r_state == BODY) && (r_beat_cnt == CNT_W'(gi));
      end
      always_ff @(posedge m_axis_h2c_aclk) begin
        if (w_wr) r_slot <= m_axis_h2c.tdata;
      end
      assign w_flat[gi*BEAT_W +: BEAT_W] = r_slot;
    end
  endgenerate

  assign w_full = {m_axis_h2c.tdata, w_flat};

  always_ff @(posedge m_axis_h2c_aclk or posedge m_axis_h2c_areset) begin
    if (m_axis_h2c_areset) begin
      r_state    <= HEAD;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_beat_cnt <= w_beat_cnt_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_beat_cnt_next = r_beat_cnt;
    w_complete      = 1'b0;
    w_len_err       = 1'b0;
    case (r_state)
      HEAD: begin
        if (w_hs) begin
          if (m_axis_h2c.tlast) begin
            w_len_err = 1'b1;
          end else begin
            w_state_next    = BODY;
            w_beat_cnt_next = CNT_W'(1);
          end
        end
      end
      BODY: begin
        if (w_hs) begin
          w_beat_cnt_next = r_beat_cnt + CNT_W'(1);
          if (r_beat_cnt == LAST_BEAT) begin
            w_beat_cnt_next = '0;
            if (m_axis_h2c.tlast) begin
              w_complete   = 1'b1;
              w_state_next = HEAD;
            end else begin
              w_len_err    = 1'b1;
              w_state_next = DROP;
            end
          end else if (m_axis_h2c.tlast) begin
            w_len_err       = 1'b1;
            w_beat_cnt_next = '0;
            w_state_next    = HEAD;
          end
        end
      end
      DROP: begin
        if (w_hs && m_axis_h2c.tlast) w_state_next = HEAD;
      end
      default: begin
        w_state_next    = HEAD;
        w_beat_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge m_axis_h2c_aclk or posedge m_axis_h2c_areset) begin
    if (m_axis_h2c_areset) begin
      r_run       <= 1'b0;
      r_data      <= '0;
      r_data_seq  <= '0;
      r_valid     <= 1'b0;
      r_seq_err   <= 1'b0;
      r_frame_err <= 1'b0;
      r_frame_cnt <= '0;
      r_exp_seq   <= '0;
      r_exp_set   <= 1'b0;
    end else begin
      r_run       <= 1'b1;
      r_seq_err   <= 1'b0;
      r_frame_err <= w_len_err;
      if (w_complete) begin
        r_data     <= w_full[8 +: DATA_WIDTH];
        r_data_seq <= w_flat[7:0];
        r_valid    <= 1'b1;
        // The very first frame after reset only seeds the expectation.
        r_seq_err  <= r_exp_set && (w_flat[7:0] != r_exp_seq);
        r_exp_seq  <= w_flat[7:0] + 8'd1;
        r_exp_set  <= 1'b1;
      end else if (w_out_hs) begin
        r_valid <= 1'b0;
      end
      if (w_out_hs) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign m_axis_h2c.tready = w_tready;
  assign m_data.data       = r_data;
  assign m_data.data_seq   = r_data_seq;
  assign m_data.data_valid = r_valid;
  assign seq_err           = r_seq_err;
  assign frame_err         = r_frame_err;
  assign frame_cnt         = r_frame_cnt;

endmodule

// File: tb/tb_axis_data_unpack.sv
// Scoreboard bench for axis_data_unpack: frames are built from a flat payload
// vector, expected deliveries are queued, and a monitor checks every delivery.

module tb_axis_data_unpack;

  localparam int DW = 4064;
  localparam int FB = (DW + 8 + 511) / 512;

  typedef struct {
    logic [DW-1:0] data;
    logic [7:0]    seq;
    logic          serr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        seq_err;
  logic        frame_err;
  logic [15:0] frame_cnt;

  axis_h2c_if #(.W(512)) h2c ();
  payload_if  #(.DW(DW)) pl ();

  axis_data_unpack #(.DATA_WIDTH(DW)) dut (
    .m_axis_h2c_aclk   (clk),
    .m_axis_h2c_areset (rst),
    .m_axis_h2c        (h2c),
    .m_data            (pl),
    .seq_err           (seq_err),
    .frame_err         (frame_err),
    .frame_cnt         (frame_cnt)
  );

  always #5 clk = ~clk;

  exp_t            sb_q[$];
  int              n_vec = 0;
  int              n_fail = 0;
  int              n_ferr_obs = 0;
  int              n_ferr_exp = 0;
  int              n_deliv_exp = 0;
  logic [7:0]      m_exp = 8'h00;
  bit              m_exp_set = 1'b0;
  int              ready_mode = 1;
  logic [FB*512-1:0] g_span;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Consumer-side ready: held low, held high, or random.
  initial begin
    pl.data_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       pl.data_ready = 1'b0;
        1:       pl.data_ready = 1'b1;
        default: pl.data_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: checks every new delivery, held-data stability and the payload at handshake.
  initial begin
    logic          pv, ph, nd;
    logic [DW-1:0] pd;
    logic [7:0]    ps;
    exp_t          e;
    int            bad;
    pv = 1'b0; ph = 1'b0; pd = '0; ps = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0;
        ph = 1'b0;
      end else begin
        nd = pl.data_valid && (!pv || ph);
        if (nd) begin
          n_vec++;
          if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_delivery: got seq %02h, expected no delivery", pl.data_seq);
          end else if (seq_err !== sb_q[0].serr) begin
            n_fail++;
            $display("FAIL seq_err_on_delivery seq=%02h: got %0b, expected %0b",
                     pl.data_seq, seq_err, sb_q[0].serr);
          end
        end else if (seq_err) begin
          n_vec++;
          n_fail++;
          $display("FAIL seq_err_idle: got 1, expected 0");
        end
        if (pl.data_valid && pv && !ph) begin
          n_vec++;
          if (pl.data !== pd || pl.data_seq !== ps) begin
            n_fail++;
            $display("FAIL held_stable: got seq %02h, expected seq %02h with unchanged data",
                     pl.data_seq, ps);
          end
        end
        if (pl.data_valid && pl.data_ready && sb_q.size() > 0) begin
          e = sb_q.pop_front();
          n_vec++;
          if (pl.data !== e.data) begin
            bad = 0;
            for (int i = 0; i < DW / 32; i++) begin
              if (pl.data[i*32 +: 32] !== e.data[i*32 +: 32]) begin
                bad = i;
                break;
              end
            end
            n_fail++;
            $display("FAIL data seq=%02h word %0d: got %08h, expected %08h",
                     e.seq, bad, pl.data[bad*32 +: 32], e.data[bad*32 +: 32]);
          end
          check("data_seq", 64'(pl.data_seq), 64'(e.seq));
          $display("deliver seq=%02h serr=%0b frame_cnt=%0d", pl.data_seq, e.serr, frame_cnt);
        end
        if (frame_err) n_ferr_obs++;
        pv = pl.data_valid;
        ph = pl.data_valid && pl.data_ready;
        pd = pl.data;
        ps = pl.data_seq;
      end
    end
  end

  task automatic rand_span();
    for (int i = 0; i < FB * 16; i++) g_span[i*32 +: 32] = $urandom();
  endtask

  function automatic logic [511:0] beat_of(input int k, input logic [7:0] seq);
    logic [511:0] b;
    if (k == 0)       b = {g_span[503:0], seq};
    else if (k < FB)  b = g_span[504 + 512*(k-1) +: 512];
    else              for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom();
    return b;
  endfunction

  task automatic model_frame(input logic [7:0] seq, input bit good);
    exp_t e;
    if (good) begin
      e.data = g_span[DW-1:0];
      e.seq  = seq;
      e.serr = m_exp_set && (seq != m_exp);
      sb_q.push_back(e);
      m_exp     = seq + 8'd1;
      m_exp_set = 1'b1;
      n_deliv_exp++;
    end else begin
      n_ferr_exp++;
    end
  endtask

  task automatic wait_hs();
    logic ok;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      ok = h2c.tready;
      @(posedge clk);
      if (ok) return;
    end
    n_fail++;
    $display("FAIL beat_timeout: got tready stuck 0, expected a handshake within 300 cycles");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $fatal(1, "beat handshake never completed");
  endtask

  // Called just after a rising edge; returns just after the handshake edge.
  task automatic send_beat(input logic [511:0] d, input logic last, input bit gaps);
    int n;
    n = (gaps && $urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
    if (n > 0) begin
      #1 h2c.tvalid = 1'b0;
      repeat (n) @(posedge clk);
    end
    #1;
    h2c.tdata  = d;
    h2c.tkeep  = '1;
    h2c.tlast  = last;
    h2c.tvalid = 1'b1;
    wait_hs();
  endtask

  task automatic end_burst();
    #1;
    h2c.tvalid = 1'b0;
    h2c.tlast  = 1'b0;
  endtask

  // mode 0: well-formed; mode 1/2: tlast on beat errbeat (early / overlong).
  task automatic send_frame(input logic [7:0] seq, input int mode, input int errbeat, input bit gaps);
    int nb;
    nb = (mode == 0) ? FB : errbeat + 1;
    model_frame(seq, mode == 0);
    $display("send seq=%02h mode=%0d beats=%0d", seq, mode, nb);
    for (int k = 0; k < nb; k++) send_beat(beat_of(k, seq), k == nb - 1, gaps);
    end_burst();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    h2c.tvalid = 1'b0;
    h2c.tlast  = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_tready",     64'(h2c.tready),     64'd0);
    check("rst_data_valid", 64'(pl.data_valid),  64'd0);
    check("rst_data_zero",  64'(|pl.data),       64'd0);
    check("rst_data_seq",   64'(pl.data_seq),    64'd0);
    check("rst_frame_cnt",  64'(frame_cnt),      64'd0);
    check("rst_errs",       64'({seq_err, frame_err}), 64'd0);
    sb_q.delete();
    m_exp_set   = 1'b0;
    n_deliv_exp = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("tready_before_edge", 64'(h2c.tready), 64'd0);
    @(posedge clk);
    #1;
    check("tready_after_edge", 64'(h2c.tready), 64'd1);
  endtask

  task automatic drain(input string tag);
    int c;
    ready_mode = 1;
    repeat (3) @(negedge clk);
    c = 0;
    while ((sb_q.size() != 0 || pl.data_valid) && c < 5000) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_drain_left"}, 64'(sb_q.size()), 64'd0);
    check({tag, "_frame_cnt"},  64'(frame_cnt),   64'(n_deliv_exp));
    check({tag, "_frame_err"},  64'(n_ferr_obs),  64'(n_ferr_exp));
    @(posedge clk);
  endtask

  initial begin
    logic [7:0] seqn;
    int r;
    h2c.tdata  = '0;
    h2c.tkeep  = '0;
    h2c.tlast  = 1'b0;
    h2c.tvalid = 1'b0;
    ready_mode = 1;

    // Single frame of incrementing words; data_valid one cycle after beat 7.
    do_reset();
    rand_span();
    for (int i = 0; i < DW / 32; i++) g_span[i*32 +: 32] = i;
    send_frame(8'h00, 0, 0, 1'b0);
    check("latency_valid", 64'(pl.data_valid), 64'd1);
    check("latency_seq",   64'(pl.data_seq),   64'd0);
    drain("single");

    // Sequence wrap FE, FF, 00 then a jump to 05.
    do_reset();
    rand_span(); send_frame(8'hFE, 0, 0, 1'b0);
    rand_span(); send_frame(8'hFF, 0, 0, 1'b0);
    rand_span(); send_frame(8'h00, 0, 0, 1'b0);
    rand_span(); send_frame(8'h05, 0, 0, 1'b0);
    drain("wrap");

    // Two frames under backpressure: final beat of frame 2 must stall.
    ready_mode = 0;
    rand_span(); send_frame(8'h06, 0, 0, 1'b0);
    rand_span();
    model_frame(8'h07, 1'b1);
    $display("send seq=07 mode=0 beats=%0d (stalled)", FB);
    for (int k = 0; k < FB - 1; k++) send_beat(beat_of(k, 8'h07), 1'b0, 1'b0);
    #1;
    h2c.tdata  = beat_of(FB - 1, 8'h07);
    h2c.tlast  = 1'b1;
    h2c.tvalid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("stall_tready", 64'(h2c.tready), 64'd0);
    end
    check("stall_held_seq", 64'(pl.data_seq), 64'h06);
    @(posedge clk);
    ready_mode = 1;
    wait_hs();
    end_burst();
    drain("backpressure");

    // Early tlast on beat 3 and on beat 0, then a good frame.
    rand_span(); send_frame(8'h08, 1, 3, 1'b0);
    rand_span(); send_frame(8'h08, 1, 0, 1'b0);
    rand_span(); send_frame(8'h08, 0, 0, 1'b0);
    drain("early");

    // Overlong frame (tlast on beat 9), then a good frame.
    rand_span(); send_frame(8'h09, 2, 9, 1'b0);
    rand_span(); send_frame(8'h09, 0, 0, 1'b0);
    drain("overlong");

    // Reset with a held output and a partial frame in flight.
    ready_mode = 0;
    rand_span(); send_frame(8'h0A, 0, 0, 1'b0);
    rand_span();
    for (int k = 0; k < 4; k++) send_beat(beat_of(k, 8'h0B), 1'b0, 1'b0);
    end_burst();
    do_reset();
    ready_mode = 1;
    rand_span(); send_frame(8'h42, 0, 0, 1'b0);
    drain("midreset");

    // Random traffic with gaps, random ready and occasional malformed frames.
    ready_mode = 2;
    seqn = 8'h43;
    for (int f = 0; f < 40; f++) begin
      rand_span();
      r = $urandom_range(0, 9);
      if (r == 0) begin
        send_frame(seqn, 1, $urandom_range(0, FB - 2), 1'(($urandom & 1)));
      end else if (r == 1) begin
        send_frame(seqn, 2, FB - 1 + $urandom_range(1, 3), 1'(($urandom & 1)));
      end else begin
        if ($urandom_range(0, 5) == 0) seqn = 8'($urandom);
        send_frame(seqn, 0, 0, 1'(($urandom & 1)));
        seqn = seqn + 8'd1;
      end
    end
    drain("random");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
